// File: rtl/regfile_mp_scoreboard_pkg.sv
// Shared register-file constants for the integer pipeline.
// Widths and the hardwired-zero index used by the register file and its users.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_mp_scoreboard_if.sv
// Read, writeback and issue bundle between the pipeline and the register file.
// master = pipeline side (decode/writeback), slave = register file.
interface regfile_mp_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
);

    logic [NUM_READ*ADDR_WIDTH-1:0]  raddr;
    logic [NUM_READ*DATA_WIDTH-1:0]  rdata;
    logic [NUM_READ-1:0]             rbusy;
    logic                            stall;
    logic [NUM_WRITE-1:0]            wen;
    logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr;
    logic [NUM_WRITE*DATA_WIDTH-1:0] wdata;
    logic                            issue_en;
    logic [ADDR_WIDTH-1:0]           issue_rd;

    modport master (
        output raddr, wen, waddr, wdata, issue_en, issue_rd,
        input  rdata, rbusy, stall
    );

    modport slave (
        input  raddr, wen, waddr, wdata, issue_en, issue_rd,
        output rdata, rbusy, stall
    );

endinterface

// File: rtl/regfile_bypass_mux.sv
// One read port: picks same-cycle writeback data over the stored value.
// Highest write port wins; index 0 always reads zero and never hits.
module regfile_bypass_mux
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_WRITE  = 1
) (
    input  logic                            en,
    input  logic [ADDR_WIDTH-1:0]           raddr,
    input  logic [NUM_WRITE-1:0]            wen,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
    input  logic [DATA_WIDTH-1:0]           arr_data,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic                            hit
);

    // Priority match over write ports; later ports override earlier ones.
    always_comb begin
        hit   = 1'b0;
        rdata = arr_data;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (en && wen[w] && raddr != '0 &&
                waddr[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr) begin
                hit   = 1'b1;
                rdata = wdata[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (raddr == '0) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with write-to-read bypass and a
// per-register busy scoreboard that raises a read-hazard stall to decode.
module regfile_mp_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_mp_scoreboard_if.slave  bus
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [NUM_READ-1:0]   hit;

    // Writeback data: highest write port wins on a shared index; x0 untouched.
    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (bus.wen[w] && bus.waddr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                regs_d[bus.waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] =
                    bus.wdata[w*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Scoreboard: retire clears first, then a new issue sets (issue wins).
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WRITE; w++) begin
            if (bus.wen[w]) begin
                busy_d[bus.waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
            end
        end
        if (bus.issue_en && bus.issue_rd != '0) begin
            busy_d[bus.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset clears data and scoreboard and drops any update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] arr_data;

        assign ra       = bus.raddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign arr_data = regs_q[ra];

        regfile_bypass_mux #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .NUM_WRITE  (NUM_WRITE)
        ) u_mux (
            .en       (rst_n),
            .raddr    (ra),
            .wen      (bus.wen),
            .waddr    (bus.waddr),
            .wdata    (bus.wdata),
            .arr_data (arr_data),
            .rdata    (bus.rdata[p*DATA_WIDTH +: DATA_WIDTH]),
            .hit      (hit[p])
        );

        assign bus.rbusy[p] = busy_q[ra] && !hit[p] && ra != '0;
    end

    assign bus.stall = |bus.rbusy;

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Bench for regfile_mp_scoreboard: directed table, reset sequence,
// then random traffic against an array/flag model of the register file.
module tb_regfile_mp_scoreboard;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_scoreboard_if #(.NUM_READ(2), .NUM_WRITE(2)) bus ();

    regfile_mp_scoreboard #(.NUM_READ(2), .NUM_WRITE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    bit          m_busy [32];

    typedef struct {
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ie;
        logic [4:0]  ird;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  eb;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] wen, logic [4:0] wa0, logic [31:0] wd0,
                         logic [4:0] wa1, logic [31:0] wd1, logic ie,
                         logic [4:0] ird, logic [4:0] ra0, logic [4:0] ra1);
        bus.wen      = wen;
        bus.waddr    = {wa1, wa0};
        bus.wdata    = {wd1, wd0};
        bus.issue_en = ie;
        bus.issue_rd = ird;
        bus.raddr    = {ra1, ra0};
    endtask

    function automatic void model_read(logic [4:0] ra, output logic [31:0] d,
                                       output bit pend);
        bit hit = 0;
        d = (ra == 0) ? 32'd0 : m_regs[ra];
        for (int w = 0; w < 2; w++) begin
            if (bus.wen[w] && ra != 0 && bus.waddr[w*5 +: 5] == ra) begin
                hit = 1;
                d = bus.wdata[w*32 +: 32];
            end
        end
        pend = (ra != 0) && m_busy[ra] && !hit;
    endfunction

    task automatic model_edge();
        logic [4:0] wa;
        for (int w = 0; w < 2; w++) begin
            wa = bus.waddr[w*5 +: 5];
            if (bus.wen[w] && wa != 0) m_regs[wa] = bus.wdata[w*32 +: 32];
        end
        for (int w = 0; w < 2; w++) begin
            if (bus.wen[w]) m_busy[bus.waddr[w*5 +: 5]] = 0;
        end
        if (bus.issue_en && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1;
        m_busy[0] = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_rdata0"}, bus.rdata[31:0], 32'd0);
        chk({tag, "_rdata1"}, bus.rdata[63:32], 32'd0);
        chk({tag, "_rbusy"}, {30'd0, bus.rbusy}, 32'd0);
        chk({tag, "_stall"}, {31'd0, bus.stall}, 32'd0);
    endtask

    initial begin
        logic [31:0] d0, d1;
        bit p0, p1;
        logic [4:0] a [4];

        tbl[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'd0, 2'b00};
        tbl[1]  = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b0, 5'd0, 5'd5,  5'd0,  32'hDEADBEEF, 32'd0, 2'b00};
        tbl[2]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0,  5'd0,  32'd0,        32'd0, 2'b00};
        tbl[3]  = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b1, 5'd7, 5'd0,  5'd7,  32'd0,        32'd0, 2'b00};
        tbl[4]  = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b0, 5'd0, 5'd0,  5'd7,  32'd0,        32'd0, 2'b10};
        tbl[5]  = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b0, 5'd0, 5'd0,  5'd7,  32'd0,        32'd0, 2'b10};
        tbl[6]  = '{2'b01, 5'd7,  32'd42,       5'd0, 32'd0, 1'b0, 5'd0, 5'd0,  5'd7,  32'd0,        32'd42, 2'b00};
        tbl[7]  = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b0, 5'd0, 5'd0,  5'd7,  32'd0,        32'd42, 2'b00};
        tbl[8]  = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b1, 5'd9, 5'd9,  5'd0,  32'd0,        32'd0, 2'b00};
        tbl[9]  = '{2'b01, 5'd9,  32'h99,       5'd0, 32'd0, 1'b1, 5'd9, 5'd9,  5'd0,  32'h99,       32'd0, 2'b00};
        tbl[10] = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b0, 5'd0, 5'd9,  5'd0,  32'h99,       32'd0, 2'b01};
        tbl[11] = '{2'b11, 5'd3,  32'd1,        5'd3, 32'd2, 1'b0, 5'd0, 5'd3,  5'd9,  32'd2,        32'h99, 2'b10};
        tbl[12] = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b0, 5'd0, 5'd3,  5'd5,  32'd2,        32'hDEADBEEF, 2'b00};
        tbl[13] = '{2'b01, 5'd11, 32'hB,        5'd0, 32'd0, 1'b0, 5'd0, 5'd11, 5'd11, 32'hB,        32'hB, 2'b00};
        tbl[14] = '{2'b00, 5'd0,  32'd0,        5'd0, 32'd0, 1'b0, 5'd0, 5'd11, 5'd11, 32'hB,        32'hB, 2'b00};

        model_reset();
        drive(2'b11, 5'd4, 32'h1234, 5'd6, 32'h5678, 1'b1, 5'd4, 5'd4, 5'd6);
        @(negedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd6);
        rst_n = 1'b1;
        #1 check_zero("reset_release");

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(tbl[i].wen, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].ie, tbl[i].ird, tbl[i].ra0, tbl[i].ra1);
            #1;
            chk($sformatf("vec%0d_rdata0", i), bus.rdata[31:0], tbl[i].e0);
            chk($sformatf("vec%0d_rdata1", i), bus.rdata[63:32], tbl[i].e1);
            chk($sformatf("vec%0d_rbusy", i), {30'd0, bus.rbusy}, {30'd0, tbl[i].eb});
            chk($sformatf("vec%0d_stall", i), {31'd0, bus.stall}, {31'd0, |tbl[i].eb});
        end

        @(negedge clk);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd9);
        @(negedge clk);
        drive(2'b01, 5'd5, 32'h55, 5'd0, 32'd0, 1'b0, 5'd0, 5'd12, 5'd9);
        #1;
        chk("pre_reset_rbusy", {30'd0, bus.rbusy}, 32'd3);
        #1 rst_n = 1'b0;
        drive(2'b01, 5'd5, 32'h55, 5'd0, 32'd0, 1'b1, 5'd13, 5'd5, 5'd9);
        #1 check_zero("mid_reset");
        @(posedge clk);
        #1 check_zero("reset_edge");
        @(negedge clk);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd13);
        rst_n = 1'b1;
        #1 check_zero("post_reset");
        model_reset();

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                a[k] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7))
                                                   : 5'($urandom_range(0, 31));
            end
            drive(2'($urandom_range(0, 3)), a[0], $urandom, a[1], $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), a[2], a[3]);
            #1;
            model_read(a[2], d0, p0);
            model_read(a[3], d1, p1);
            chk("rnd_rdata0", bus.rdata[31:0], d0);
            chk("rnd_rdata1", bus.rdata[63:32], d1);
            chk("rnd_rbusy", {30'd0, bus.rbusy}, {30'd0, p1, p0});
            chk("rnd_stall", {31'd0, bus.stall}, {31'd0, p0 | p1});
            @(posedge clk);
            model_edge();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
